rr_arbiter_8: RTL and testbench
===============================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of consecutive cycles one grant may be held while other requests are pending; legal range 2..255.
REQ-002 SHALL have port sys_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port req, input, 8 bits, request lines; bit i is requester i, level-sensitive.
REQ-005 SHALL have port gnt, output, 8 bits, registered one-hot grant, or all-zero when no grant is active.
REQ-006 SHALL have port gnt_idx, output, 3 bits, registered binary index of the granted requester, 0 when no grant is active.
REQ-007 SHALL have port gnt_valid, output, 1 bit, registered; 1 while any grant is active.
REQ-008 SHALL have port hold_expired, output, 1 bit, registered one-cycle pulse on forced revocation.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one requester owns the resource).
REQ-010 In IDLE with req != 0, SHALL select the first set req bit searching upward from the priority pointer ptr[2:0] with wrap 7->0, then enter GRANT at the next edge.
REQ-011 The grant outputs SHALL appear one cycle after the sampled request, with gnt = 1<<gnt_idx and gnt_valid = 1.
REQ-012 In IDLE with req == 0, SHALL remain in IDLE with gnt = 0, gnt_idx = 0 and gnt_valid = 0.
REQ-013 On every grant issue, SHALL set ptr = (granted index + 1) mod 8, so index 7 wraps to 0.
REQ-014 In GRANT, SHALL hold gnt, gnt_idx and the owner unchanged while req[gnt_idx] = 1, whatever the other req bits do.
REQ-015 In GRANT, when req[gnt_idx] = 0 is sampled, SHALL return to IDLE at that edge, clearing gnt, gnt_idx and gnt_valid.
REQ-016 After any release, SHALL insert at least one IDLE cycle with gnt = 0 before the next grant, so grants never switch back-to-back.
REQ-017 Owner-change latency SHALL be 2 cycles: release sampled -> IDLE -> new grant.
REQ-018 A requester that drops and re-raises its req in the same IDLE cycle SHALL be arbitrated normally under the current ptr.
REQ-019 When the same requester is the sole requester again, SHALL re-grant it after the mandatory IDLE cycle.
REQ-020 Changes on req bits other than the owner's during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-021 SHALL hold gnt one-hot or zero at all times, and gnt_valid = |gnt.

Reset
REQ-022 Assertion of sys_rst_n = 0 SHALL immediately force state = IDLE, ptr = 0, gnt = 0, gnt_idx = 0, gnt_valid = 0, hold_expired = 0, and hold counter = 0.
REQ-023 Reset asserted mid-grant SHALL drop the grant asynchronously without waiting for a clock edge.
REQ-024 After reset deassertion, the first arbitration SHALL start from ptr = 0.

Configuration
REQ-025 Macro ARB_HOLD_LIMIT_EN SHALL compile in the hold limiter, consisting of a hold counter and the hold_expired logic.
REQ-026 With ARB_HOLD_LIMIT_EN defined, SHALL clear the hold counter on grant issue and increment it each cycle in GRANT, saturating at MAX_HOLD-1.
REQ-027 With ARB_HOLD_LIMIT_EN defined, when counter = MAX_HOLD-1 and (req & ~gnt) != 0, SHALL go to IDLE and pulse hold_expired for exactly one cycle.
REQ-028 With ARB_HOLD_LIMIT_EN defined, when the counter is saturated and no other request is pending, SHALL keep the grant with no pulse.
REQ-029 With ARB_HOLD_LIMIT_EN defined, a release and an expiry in the same cycle SHALL count as a release with no hold_expired pulse.
REQ-030 Without ARB_HOLD_LIMIT_EN, SHALL contain no counter, hold grants indefinitely, tie hold_expired to 0, and ignore MAX_HOLD.

Verification
REQ-031 Bench SHALL cover: reset, then req = 8'h81 held -> gnt = 8'h01 at cycle 1 and gnt_idx = 0; drop req[0] -> gnt = 0 for one cycle, then gnt = 8'h80 and gnt_idx = 7.
REQ-032 Bench SHALL cover wrap-around: owner 7 released while req = 8'h81 -> next grant is 0, because ptr wrapped to 0.
REQ-033 Bench SHALL cover fairness: req = 8'hFF, each owner releasing after 3 cycles -> grant order 0,1,...,7,0 with exactly 1 idle cycle between grants.
REQ-034 Bench SHALL cover reset mid-grant: sys_rst_n pulled low between clock edges while gnt = 8'h04 -> all outputs 0 before the next edge; after release, req = 8'h0C -> gnt = 8'h04.
REQ-035 Bench SHALL cover the limiter with ARB_HOLD_LIMIT_EN and MAX_HOLD = 4: req = 8'h03 held -> owner 0 for 4 cycles, hold_expired = 1 for one cycle, then owner 1 after one idle cycle.
REQ-036 Bench SHALL cover the limiter with ARB_HOLD_LIMIT_EN and req = 8'h01 only -> grant held beyond MAX_HOLD and hold_expired stays 0.
REQ-037 Bench SHALL check, every cycle in all scenarios, that gnt is one-hot or zero and that gnt = 1<<gnt_idx whenever gnt_valid = 1.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant and a mandatory idle cycle between owners.
// Define ARB_HOLD_LIMIT_EN to compile in the hold limiter (MAX_HOLD bounds a contended grant).
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       hold_expired
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic [2:0] owner_nxt;
  logic [2:0] pick_idx;
  logic       pick_found;
  logic       expire;
  logic [7:0] gnt_nxt;
  logic [2:0] gnt_idx_nxt;
  logic       gnt_valid_nxt;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_8: MAX_HOLD must lie in 2..255");
  end

  // First set request at or above ptr, wrapping 7 -> 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    for (int k = 0; k < 8; k++) begin
      if (!pick_found && req[ptr + 3'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr + 3'(k);
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;
  logic [7:0] hold_cnt_nxt;
  logic       hold_expired_nxt;

  assign expire = (hold_cnt == HOLD_LAST) && ((req & ~gnt) != 8'h00);

  // Counter restarts on every new grant and saturates while the owner keeps it.
  always_comb begin
    hold_cnt_nxt = 8'h00;
    if (state == GRANT && state_nxt == GRANT && hold_cnt != HOLD_LAST) begin
      hold_cnt_nxt = hold_cnt + 8'h01;
    end else if (state == GRANT && state_nxt == GRANT) begin
      hold_cnt_nxt = hold_cnt;
    end
  end

  // A release wins over a simultaneous expiry, so the pulse needs the owner still requesting.
  always_comb begin
    hold_expired_nxt = (state == GRANT) && req[gnt_idx] && expire;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt     <= 8'h00;
      hold_expired <= 1'b0;
    end else begin
      hold_cnt     <= hold_cnt_nxt;
      hold_expired <= hold_expired_nxt;
    end
  end
`else
  assign expire       = 1'b0;
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= gnt_idx_nxt;
      gnt_valid <= gnt_valid_nxt;
    end
  end

  // Leaving GRANT always passes through IDLE, which gives the one-cycle gap between owners.
  always_comb begin
    state_nxt = state;
    owner_nxt = gnt_idx;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          owner_nxt = pick_idx;
          ptr_nxt   = pick_idx + 3'd1;
        end
      end
      GRANT: begin
        if (!req[gnt_idx] || expire) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    gnt_nxt       = 8'h00;
    gnt_idx_nxt   = 3'd0;
    gnt_valid_nxt = 1'b0;
    if (state_nxt == GRANT) begin
      gnt_nxt       = 8'h01 << owner_nxt;
      gnt_idx_nxt   = owner_nxt;
      gnt_valid_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: a behavioural model fills a scoreboard queue, each cycle's outputs are popped and checked.
// Limiter scenarios are selected with ARB_HOLD_LIMIT_EN.
module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 4;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       hold_expired;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       expired;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req         (req),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .hold_expired(hold_expired)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    sb_q.delete();
  endtask

  // Behavioural view of one clock edge given the sampled request vector.
  function automatic exp_t model_step(input logic [7:0] r);
    exp_t e;
    logic [7:0] others;
    e.expired = 1'b0;
    others    = r & ~(8'h01 << m_owner);
    if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        if (r[(m_ptr + k) % 8]) begin
          m_busy  = 1'b1;
          m_owner = (m_ptr + k) % 8;
          m_ptr   = (m_owner + 1) % 8;
          m_cnt   = 0;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_busy = 1'b0;
    end else if (LIMIT_EN && m_cnt == MAX_HOLD - 1 && others != 8'h00) begin
      m_busy    = 1'b0;
      e.expired = 1'b1;
    end else if (m_cnt < MAX_HOLD - 1) begin
      m_cnt++;
    end
    e.gnt   = m_busy ? (8'h01 << m_owner) : 8'h00;
    e.idx   = m_busy ? 3'(m_owner) : 3'd0;
    e.valid = m_busy;
    return e;
  endfunction

  task automatic checkOutput(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    compare({tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
    compare({tag, "_idx"}, 32'(gnt_idx), 32'(e.idx));
    compare({tag, "_valid"}, 32'(gnt_valid), 32'(e.valid));
    compare({tag, "_hexp"}, 32'(hold_expired), 32'(e.expired));
    compare({tag, "_onehot0"}, 32'($onehot0(gnt)), 32'd1);
    compare({tag, "_valid_or"}, 32'(gnt_valid), 32'(|gnt));
    if (gnt_valid) begin
      compare({tag, "_gnt_idx"}, 32'(gnt), 32'(8'h01 << gnt_idx));
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input string tag);
    req = r;
    sb_q.push_back(model_step(r));
    @(posedge sys_clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic do_reset(input string tag);
    sys_rst_n = 1'b0;
    req       = 8'h00;
    #1;
    compare({tag, "_gnt"}, 32'(gnt), 32'h0);
    compare({tag, "_idx"}, 32'(gnt_idx), 32'h0);
    compare({tag, "_valid"}, 32'(gnt_valid), 32'h0);
    compare({tag, "_hexp"}, 32'(hold_expired), 32'h0);
    model_reset();
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b1;
    req       = 8'h00;
    model_reset();
    #1;
    do_reset("rst0");
    applyStimulus(8'h00, "idle");
    compare("idle_gnt", 32'(gnt), 32'h0);

    // Basic grant, release, idle gap, next owner.
    applyStimulus(8'h81, "s1_c1");
    compare("s1_first_gnt", 32'(gnt), 32'h01);
    compare("s1_first_idx", 32'(gnt_idx), 32'd0);
    applyStimulus(8'h81, "s1_hold");
    applyStimulus(8'h81, "s1_hold");
    applyStimulus(8'h80, "s1_drop0");
    compare("s1_idle_gap", 32'(gnt), 32'h0);
    applyStimulus(8'h80, "s1_next");
    compare("s1_next_gnt", 32'(gnt), 32'h80);
    compare("s1_next_idx", 32'(gnt_idx), 32'd7);

    // Owner 7 releases while 0 is pending: pointer has wrapped to 0.
    applyStimulus(8'h81, "s2_hold7");
    applyStimulus(8'h01, "s2_rel7");
    compare("s2_idle_gap", 32'(gnt), 32'h0);
    applyStimulus(8'h81, "s2_wrap");
    compare("s2_wrap_gnt", 32'(gnt), 32'h01);

    // Other requesters toggling during a grant change nothing.
    applyStimulus(8'hFF, "s3_noise");
    applyStimulus(8'h0F, "s3_noise");
    applyStimulus(8'hA1, "s3_noise");
    compare("s3_owner_kept", 32'(gnt), 32'h01);

    // Sole requester re-granted after the idle cycle.
    applyStimulus(8'h00, "s4_rel");
    applyStimulus(8'h01, "s4_regrant");
    compare("s4_regrant_gnt", 32'(gnt), 32'h01);

    // Drop and re-raise in the same idle cycle: arbitration uses the moved pointer.
    applyStimulus(8'h05, "s5_hold");
    applyStimulus(8'h04, "s5_rel");
    applyStimulus(8'h05, "s5_reraise");
    compare("s5_reraise_gnt", 32'(gnt), 32'h04);
    applyStimulus(8'h00, "s5_end");

    // Asynchronous reset in the middle of a grant.
    do_reset("rst1");
    applyStimulus(8'h04, "s6_grant");
    compare("s6_grant_gnt", 32'(gnt), 32'h04);
    #2;
    do_reset("rst_mid");
    applyStimulus(8'h0C, "s6_after");
    compare("s6_after_gnt", 32'(gnt), 32'h04);
    applyStimulus(8'h00, "s6_end");

    // Fairness: everyone requesting, each owner keeps the grant three cycles.
    do_reset("rst2");
    for (int g = 0; g < 9; g++) begin
      applyStimulus(8'hFF, "fair_grant");
      compare("fair_order", 32'(gnt_idx), 32'(g % 8));
      compare("fair_valid", 32'(gnt_valid), 32'd1);
      if (g < 8) begin
        applyStimulus(8'hFF, "fair_hold");
        applyStimulus(8'hFF, "fair_hold");
        applyStimulus(8'hFF & ~(8'h01 << (g % 8)), "fair_rel");
        compare("fair_idle", 32'(gnt), 32'h0);
      end
    end
    applyStimulus(8'h00, "fair_end");

`ifdef ARB_HOLD_LIMIT_EN
    // Contended owner is revoked after MAX_HOLD cycles.
    do_reset("rst3");
    for (int c = 0; c < MAX_HOLD; c++) begin
      applyStimulus(8'h03, "lim_hold");
      compare("lim_owner0", 32'(gnt), 32'h01);
    end
    applyStimulus(8'h03, "lim_expire");
    compare("lim_expire_gnt", 32'(gnt), 32'h0);
    compare("lim_expire_pulse", 32'(hold_expired), 32'd1);
    applyStimulus(8'h03, "lim_next");
    compare("lim_next_gnt", 32'(gnt), 32'h02);
    compare("lim_pulse_gone", 32'(hold_expired), 32'd0);
    for (int c = 1; c < MAX_HOLD; c++) begin
      applyStimulus(8'h03, "lim_hold1");
    end
    applyStimulus(8'h01, "lim_rel_at_expiry");
    compare("lim_rel_no_pulse", 32'(hold_expired), 32'd0);
    applyStimulus(8'h01, "lim_after_rel");
    compare("lim_after_rel_gnt", 32'(gnt), 32'h01);

    // Uncontended owner keeps the grant past MAX_HOLD.
    do_reset("rst4");
    for (int c = 0; c < 3 * MAX_HOLD; c++) begin
      applyStimulus(8'h01, "lim_solo");
      compare("lim_solo_gnt", 32'(gnt), 32'h01);
      compare("lim_solo_pulse", 32'(hold_expired), 32'd0);
    end
`else
    // Without the limiter a contended grant is held indefinitely.
    do_reset("rst3");
    for (int c = 0; c < 3 * MAX_HOLD; c++) begin
      applyStimulus(8'h03, "nolim_hold");
      compare("nolim_gnt", 32'(gnt), 32'h01);
      compare("nolim_pulse", 32'(hold_expired), 32'd0);
    end
`endif
    applyStimulus(8'h00, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
